// File: rtl/mem_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_pkg;

    localparam int XLEN                 = 32;
    localparam int DEPTH_DEFAULT        = 2;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } mem_src_e;

endpackage

// File: rtl/mem_arbiter_chk.sv
// Protocol checks for the downstream response channel of mem_arbiter.
module mem_arbiter_chk (
    input logic clk,
    input logic rst,
    input logic m_data_ok,
    input logic q_empty
);

    // A downstream response with nothing outstanding has no owner.
    a_no_orphan_resp: assert property (@(posedge clk) disable iff (rst)
        !(m_data_ok && q_empty))
        else $error("m_data_ok asserted with no outstanding request");

endmodule

// File: rtl/mem_id_fifo.sv
// In-order queue of requester IDs for accepted-but-unanswered memory requests.
module mem_id_fifo
    import mem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  mem_src_e din,
    output mem_src_e dout,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    mem_src_e           mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic               do_push_s;
    logic               do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // A push into a full queue is legal only when the head leaves in the same cycle.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // ID storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_arbiter.sv
// Two-to-one arbiter sharing one memory port between instruction fetch and load/store,
// with in-order response routing and a bounded fetch starvation window.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_write,
    input  logic [XLEN/8-1:0] i_wstrb,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [XLEN-1:0]   i_rdata,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [XLEN/8-1:0] d_wstrb,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [XLEN-1:0]   d_rdata,
    output logic              m_req,
    output logic              m_write,
    output logic [XLEN/8-1:0] m_wstrb,
    output logic [XLEN-1:0]   m_addr,
    output logic [XLEN-1:0]   m_wdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok,
    input  logic [XLEN-1:0]   m_rdata
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_cnt_r;
    logic [STARVE_W-1:0] starve_nxt_s;
    logic                i_win_s;
    logic                win_req_s;
    logic                m_xfer_s;
    logic                pop_s;
    logic                q_full_s;
    logic                q_empty_s;
    mem_src_e            q_head_s;
    mem_src_e            push_src_s;

    // Arbitration, request mux and response routing; all paths are combinational.
    always_comb begin
        pop_s      = m_data_ok & ~q_empty_s & ~rst;
        i_win_s    = i_req & ((starve_cnt_r == STARVE_W'(STARVE_LIMIT)) | ~d_req);
        win_req_s  = i_req | d_req;
        m_req      = win_req_s & ~(q_full_s & ~pop_s) & ~rst;
        m_write    = i_win_s ? i_write : d_write;
        m_wstrb    = i_win_s ? i_wstrb : d_wstrb;
        m_addr     = i_win_s ? i_addr  : d_addr;
        m_wdata    = i_win_s ? i_wdata : d_wdata;
        m_xfer_s   = m_req & m_addr_ok;
        i_addr_ok  = m_xfer_s & i_win_s;
        d_addr_ok  = m_xfer_s & ~i_win_s;
        push_src_s = i_win_s ? SRC_I : SRC_D;
        i_data_ok  = pop_s & (q_head_s == SRC_I);
        d_data_ok  = pop_s & (q_head_s == SRC_D);
        i_rdata    = m_rdata;
        d_rdata    = m_rdata;
    end

    // Fetch starvation count: saturates while fetch waits, clears once it is served or idle.
    always_comb begin
        starve_nxt_s = starve_cnt_r;
        if (~i_req | i_addr_ok) begin
            starve_nxt_s = {STARVE_W{1'b0}};
        end else if (starve_cnt_r != STARVE_W'(STARVE_LIMIT)) begin
            starve_nxt_s = starve_cnt_r + STARVE_W'(1);
        end else begin
            starve_nxt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_r <= {STARVE_W{1'b0}};
        end else begin
            starve_cnt_r <= starve_nxt_s;
        end
    end

    mem_id_fifo #(
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (m_xfer_s),
        .pop   (pop_s),
        .din   (push_src_s),
        .dout  (q_head_s),
        .full  (q_full_s),
        .empty (q_empty_s)
    );

    mem_arbiter_chk u_chk (
        .clk       (clk),
        .rst       (rst),
        .m_data_ok (m_data_ok),
        .q_empty   (q_empty_s)
    );

endmodule
